// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and request-kind encodings for the memory arbiter.
package mem_arbiter_pkg;
    localparam int ROB_IDX_W = 6;
    typedef logic [31:0] addr_tp;
    typedef logic [31:0] word_tp;
    typedef logic [ROB_IDX_W-1:0] rob_idx_tp;
    typedef enum logic [1:0] {
        MEM_KIND_FETCH = 2'd0,
        MEM_KIND_LOAD  = 2'd1,
        MEM_KIND_STORE = 2'd2
    } mem_kind_tp;
    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_tp;
    typedef struct packed {
        mem_kind_tp kind;
        addr_tp     addr;
        word_tp     data;
        logic [3:0] len;
        logic       sext;
        rob_idx_tp  src;
    } mem_req_tp;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, control and memory-controller signals of the memory arbiter.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;
    logic       rdy, rb;
    logic       fc_valid, fc_done;
    addr_tp     fc_addr;
    logic       st_valid, st_done;
    addr_tp     st_addr;
    word_tp     st_data;
    logic [3:0] st_len;
    logic       ld_valid, ld_done, ld_sext;
    addr_tp     ld_addr;
    logic [3:0] ld_len;
    rob_idx_tp  ld_src;
    logic       mem_req_valid, mem_req_sext, mem_abort, mem_done;
    mem_kind_tp mem_req_kind;
    addr_tp     mem_req_addr;
    word_tp     mem_req_data;
    logic [3:0] mem_req_len;
    rob_idx_tp  mem_req_src;
    modport master (
        input  rdy, rb, fc_valid, fc_addr, st_valid, st_addr, st_data, st_len,
               ld_valid, ld_addr, ld_len, ld_sext, ld_src, mem_done,
        output fc_done, st_done, ld_done, mem_req_valid, mem_req_kind, mem_req_addr,
               mem_req_data, mem_req_len, mem_req_sext, mem_req_src, mem_abort
    );
    modport slave (
        output rdy, rb, fc_valid, fc_addr, st_valid, st_addr, st_data, st_len,
               ld_valid, ld_addr, ld_len, ld_sext, ld_src, mem_done,
        input  fc_done, st_done, ld_done, mem_req_valid, mem_req_kind, mem_req_addr,
               mem_req_data, mem_req_len, mem_req_sext, mem_req_src, mem_abort
    );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational priority selector; an aged fetch beats store, store beats load, load beats fetch.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       fc_valid_i,
    input  logic       st_valid_i,
    input  logic       ld_valid_i,
    input  logic       rb_i,
    input  logic       age_hit_i,
    output mem_kind_tp gnt_kind_o,
    output logic       gnt_valid_o
);
    logic ld_ok;
    assign ld_ok       = ld_valid_i & ~rb_i;
    assign gnt_valid_o = fc_valid_i | st_valid_i | ld_ok;
    assign gnt_kind_o  = (fc_valid_i & age_hit_i) ? MEM_KIND_FETCH :
                         st_valid_i               ? MEM_KIND_STORE :
                         ld_ok                    ? MEM_KIND_LOAD  : MEM_KIND_FETCH;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the memory-controller port among fetch, store and load requesters.
// Define MEM_ARB_AGING_EN to add the fetch age counter that guarantees fetch forward progress.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AGE_LIMIT = 4
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.master bus
);
    arb_state_tp state_q, state_d;
    mem_req_tp   req_q, req_d, req_new;
    logic        valid_q, valid_d;
    logic        busy, abort, done_ok, age_hit, gnt_valid;
    mem_kind_tp  gnt_kind;

    mem_arb_pick u_pick (
        .fc_valid_i (bus.fc_valid),
        .st_valid_i (bus.st_valid),
        .ld_valid_i (bus.ld_valid),
        .rb_i       (bus.rb),
        .age_hit_i  (age_hit),
        .gnt_kind_o (gnt_kind),
        .gnt_valid_o(gnt_valid)
    );

    assign busy    = state_q == ARB_BUSY;
    // a rollback on an in-flight load wins over a coincident completion
    assign abort   = bus.rdy & busy & bus.rb & (req_q.kind == MEM_KIND_LOAD);
    assign done_ok = bus.rdy & busy & bus.mem_done & ~abort;

    assign bus.fc_done       = done_ok & (req_q.kind == MEM_KIND_FETCH);
    assign bus.st_done       = done_ok & (req_q.kind == MEM_KIND_STORE);
    assign bus.ld_done       = done_ok & (req_q.kind == MEM_KIND_LOAD);
    assign bus.mem_abort     = abort;
    assign bus.mem_req_valid = valid_q;
    assign bus.mem_req_kind  = req_q.kind;
    assign bus.mem_req_addr  = req_q.addr;
    assign bus.mem_req_data  = req_q.data;
    assign bus.mem_req_len   = req_q.len;
    assign bus.mem_req_sext  = req_q.sext;
    assign bus.mem_req_src   = req_q.src;

    always_comb begin
        req_new.kind = gnt_kind;
        req_new.addr = gnt_kind == MEM_KIND_STORE ? bus.st_addr :
                       gnt_kind == MEM_KIND_LOAD  ? bus.ld_addr : bus.fc_addr;
        req_new.data = gnt_kind == MEM_KIND_STORE ? bus.st_data : '0;
        req_new.len  = gnt_kind == MEM_KIND_STORE ? bus.st_len :
                       gnt_kind == MEM_KIND_LOAD  ? bus.ld_len : '0;
        req_new.sext = (gnt_kind == MEM_KIND_LOAD) & bus.ld_sext;
        req_new.src  = gnt_kind == MEM_KIND_LOAD ? bus.ld_src : '0;
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        valid_d = valid_q;
        if (bus.rdy && !busy && gnt_valid) begin
            state_d = ARB_BUSY;
            req_d   = req_new;
            valid_d = 1'b1;
        end else if (done_ok || abort) begin
            state_d = ARB_IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            req_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

`ifdef MEM_ARB_AGING_EN
    logic [2:0] age_q, age_d;
    assign age_hit = age_q >= 3'(AGE_LIMIT);
    // counts arbitrations lost by a waiting fetch, saturating at 7
    always_comb begin
        age_d = !bus.rdy                                       ? age_q :
                !bus.fc_valid                                  ? 3'd0  :
                (busy || !gnt_valid)                           ? age_q :
                gnt_kind == MEM_KIND_FETCH                     ? 3'd0  :
                age_q == 3'd7                                  ? age_q : age_q + 3'd1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) age_q <= 3'd0;
        else        age_q <= age_d;
    end
`else
    assign age_hit = 1'b0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a grant scoreboard checked by an independent monitor.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;
`ifdef MEM_ARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    mem_req_tp exp_q[$];
    int        exp_cyc_q[$];

    mem_arbiter_if bus ();
    mem_arbiter #(.AGE_LIMIT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic grant(input mem_kind_tp k, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] l, input logic s, input logic [5:0] src);
        mem_req_tp r;
        r.kind = k; r.addr = a; r.data = d; r.len = l; r.sext = s; r.src = src;
        exp_q.push_back(r);
        exp_cyc_q.push_back(cyc + 1);
    endtask

    task automatic finish_req(input logic [2:0] exp_done);
        bus.mem_done = 1'b1;
        #1 chk("done outputs", {bus.fc_done, bus.st_done, bus.ld_done}, exp_done);
        @(negedge clk);
        bus.mem_done = 1'b0;
        #1 chk("idle after done", bus.mem_req_valid, 1'b0);
    endtask

    initial begin : monitor
        logic prev_v;
        mem_req_tp act, exp;
        int ecyc;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) prev_v = 1'b0;
            else begin
                if (bus.mem_req_valid && !prev_v) begin
                    act.kind = bus.mem_req_kind; act.addr = bus.mem_req_addr;
                    act.data = bus.mem_req_data; act.len = bus.mem_req_len;
                    act.sext = bus.mem_req_sext; act.src = bus.mem_req_src;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected grant: got %0h expected none (cycle %0d)", act, cyc);
                    end else begin
                        exp = exp_q.pop_front();
                        ecyc = exp_cyc_q.pop_front();
                        chk("grant fields", act, exp);
                        chk("grant cycle", cyc, ecyc);
                    end
                end
                prev_v = bus.mem_req_valid;
            end
        end
    end

    initial begin
        bus.rdy = 1'b1; bus.rb = 1'b0; bus.mem_done = 1'b0;
        bus.fc_valid = 1'b0; bus.fc_addr = '0;
        bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_len = '0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_len = '0; bus.ld_sext = 1'b0; bus.ld_src = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset valid", bus.mem_req_valid, 1'b0);
        chk("reset kind/addr", {bus.mem_req_kind, bus.mem_req_addr}, 0);
        chk("reset done/abort", {bus.fc_done, bus.st_done, bus.ld_done, bus.mem_abort}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        // fetch alone, completion 18 cycles after grant
        bus.fc_valid = 1'b1; bus.fc_addr = 32'h100;
        grant(MEM_KIND_FETCH, 32'h100, 0, 0, 0, 0);
        @(negedge clk);
        repeat (18) @(negedge clk);
        finish_req(3'b100);
        bus.fc_valid = 1'b0;
        // store and load together: store first, load after one dead cycle
        bus.st_valid = 1'b1; bus.st_addr = 32'h20; bus.st_data = 32'hDEADBEEF; bus.st_len = 4'd3;
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h40; bus.ld_len = 4'd2; bus.ld_sext = 1'b1; bus.ld_src = 6'd5;
        grant(MEM_KIND_STORE, 32'h20, 32'hDEADBEEF, 4'd3, 1'b0, 6'd0);
        repeat (4) @(negedge clk);
        finish_req(3'b010);
        bus.st_valid = 1'b0;
        grant(MEM_KIND_LOAD, 32'h40, 0, 4'd2, 1'b1, 6'd5);
        @(negedge clk);
        bus.fc_valid = 1'b1; bus.fc_addr = 32'h200;
        repeat (3) @(negedge clk);
        // rollback with coincident completion: abort wins
        bus.rb = 1'b1; bus.mem_done = 1'b1;
        #1 chk("abort asserted", bus.mem_abort, 1'b1);
        chk("no done on abort", {bus.fc_done, bus.st_done, bus.ld_done}, 0);
        @(negedge clk);
        bus.rb = 1'b0; bus.mem_done = 1'b0; bus.ld_valid = 1'b0;
        #1 chk("abort one cycle", bus.mem_abort, 1'b0);
        chk("idle after abort", bus.mem_req_valid, 1'b0);
        grant(MEM_KIND_FETCH, 32'h200, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        finish_req(3'b100);
        bus.fc_valid = 1'b0;
        // store ignores rollback, then rdy low freezes it through a done pulse
        bus.st_valid = 1'b1; bus.st_addr = 32'h80; bus.st_data = 32'h12345678; bus.st_len = 4'd4;
        grant(MEM_KIND_STORE, 32'h80, 32'h12345678, 4'd4, 1'b0, 6'd0);
        repeat (2) @(negedge clk);
        bus.rb = 1'b1;
        #1 chk("no abort on store", bus.mem_abort, 1'b0);
        @(negedge clk);
        bus.rb = 1'b0;
        #1 chk("store survives rb", bus.mem_req_valid, 1'b1);
        bus.rdy = 1'b0;
        repeat (2) @(negedge clk);
        bus.mem_done = 1'b1;
        #1 chk("rdy low no done", {bus.fc_done, bus.st_done, bus.ld_done}, 0);
        @(negedge clk);
        bus.mem_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("frozen valid", bus.mem_req_valid, 1'b1);
        chk("frozen addr", bus.mem_req_addr, 32'h80);
        bus.rdy = 1'b1;
        @(negedge clk);
        finish_req(3'b010);
        bus.st_valid = 1'b0;
        // continuous stores with a waiting fetch
        bus.st_valid = 1'b1; bus.st_addr = 32'h400; bus.st_data = 32'h55; bus.st_len = 4'd1;
        bus.fc_valid = 1'b1; bus.fc_addr = 32'h300;
        for (int i = 1; i <= 5; i++) begin
            if (AGING && i == 5) grant(MEM_KIND_FETCH, 32'h300, 0, 0, 0, 0);
            else                 grant(MEM_KIND_STORE, 32'h400, 32'h55, 4'd1, 1'b0, 6'd0);
            repeat (3) @(negedge clk);
            finish_req((AGING && i == 5) ? 3'b100 : 3'b010);
        end
        bus.st_valid = 1'b0; bus.fc_valid = 1'b0;
        // reset in the middle of a store, then re-grant with the same fields
        bus.st_valid = 1'b1; bus.st_addr = 32'h500; bus.st_data = 32'hCAFEF00D; bus.st_len = 4'd2;
        grant(MEM_KIND_STORE, 32'h500, 32'hCAFEF00D, 4'd2, 1'b0, 6'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1 chk("reset drops valid", bus.mem_req_valid, 1'b0);
        chk("reset clears fields", {bus.mem_req_addr, bus.mem_req_data, bus.mem_req_len}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        grant(MEM_KIND_STORE, 32'h500, 32'hCAFEF00D, 4'd2, 1'b0, 6'd0);
        repeat (3) @(negedge clk);
        finish_req(3'b010);
        bus.st_valid = 1'b0;
        // completion pulse while idle is ignored
        @(negedge clk);
        bus.mem_done = 1'b1;
        #1 chk("idle done ignored", {bus.fc_done, bus.st_done, bus.ld_done}, 0);
        @(negedge clk);
        bus.mem_done = 1'b0;
        #1 chk("stays idle", bus.mem_req_valid, 1'b0);
        repeat (3) @(negedge clk);
        chk("all grants seen", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer that shares the single memory-controller request port between three requesters: instruction-cache line fetch, store-buffer commit and load-buffer read. It sits between the icache/SLB and the memory controller, latching one request at a time, holding it stable until the controller completes it, and routing completion back to the owner. It also cancels in-flight loads on rollback and, when enabled, guarantees fetch forward progress under heavy load/store traffic.

## Interface
- `AGE_LIMIT`, 4: consecutive lost arbitrations after which a waiting fetch gets top priority (1..7).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rdy` in 1: global ready; low freezes all state.
- `rb` in 1: rollback; cancels pending/in-flight loads.
- `fc_valid` in 1 / `fc_addr` in 32 / `fc_done` out 1: icache fetch request; done is 1-cycle pulse.
- `st_valid` in 1 / `st_addr` in 32 / `st_data` in 32 / `st_len` in 4 / `st_done` out 1: store request.
- `ld_valid` in 1 / `ld_addr` in 32 / `ld_len` in 4 / `ld_sext` in 1 / `ld_src` in ROB_IDX width / `ld_done` out 1: load request.
- `mem_req_valid` out 1: request presented to memory controller.
- `mem_req_kind` out 2: FETCH=0, LOAD=1, STORE=2.
- `mem_req_addr` out 32, `mem_req_data` out 32, `mem_req_len` out 4, `mem_req_sext` out 1, `mem_req_src` out ROB_IDX width: latched request fields.
- `mem_abort` out 1: 1-cycle pulse telling controller to drop the current load.
- `mem_done` in 1: controller completion pulse for the current request.

## Operation
- States: IDLE, BUSY.
- IDLE: pick among valid requesters; winner's fields latched into `mem_req_*`, `mem_req_valid`<=1, state<=BUSY. No valid requester: stay IDLE.
- Priority without aging: STORE > LOAD (only if `rb`=0) > FETCH.
- BUSY: `mem_req_*` held constant. On `mem_done`: owner's done output = 1 same cycle (combinational from `mem_done` and latched kind), `mem_req_valid`<=0, state<=IDLE.
- Requesters hold valid and fields stable until their done; dropping valid while granted is illegal except load under `rb`.
- `rb` in BUSY with kind LOAD: `mem_abort`=1 for one cycle, `mem_req_valid`<=0, state<=IDLE, no `ld_done`. `mem_done` coinciding with `rb` on a load: abort wins, `ld_done`=0.
- `rb` during STORE or FETCH: no effect; request completes normally.
- `rdy`=0: state, latches, counter frozen; done outputs and `mem_abort` forced 0.
- `mem_done` while IDLE: ignored.
- Reset values: all outputs 0, state IDLE, age counter 0.

## Timing
- Request visible in IDLE at cycle N -> `mem_req_valid`=1 at N+1.
- `mem_done` at cycle M -> owner done at M, IDLE at M+1, next grant visible at M+2 earliest (one dead cycle).
- `mem_abort` asserted in the cycle `rb` is sampled in BUSY; IDLE next cycle.
- Reset mid-transaction: immediate return to IDLE, `mem_req_valid`=0 asynchronously.

## Configuration
- `MEM_ARB_AGING_EN` defined: 3-bit age counter increments each IDLE arbitration where `fc_valid`=1 and fetch loses; cleared when fetch is granted or `fc_valid`=0. Counter >= `AGE_LIMIT` -> FETCH beats STORE and LOAD for that arbitration. Counter saturates at 7.
- Undefined: fixed priority only; no counter logic.

## Structure
- Shared package (utils.v): kind encodings `MEM_KIND_FETCH/LOAD/STORE`, `MEM_KIND_TP` 1:0, reuse existing `ADDR_TP`, `WORD_TP`, `ROB_IDX_TP`.
- One sub-module `mem_arb_pick`: combinational priority/aging selector (inputs valids, rb, age_hit; output grant kind and grant valid).

## Test plan
- Fetch only, addr 0x100, `mem_done` 18 cycles after grant -> `mem_req_kind`=0, addr 0x100 at N+1; `fc_done` pulse same cycle as `mem_done`.
- Store (addr 0x20, data 0xDEADBEEF, len 3) and load same cycle -> store granted first; load granted 2 cycles after `st_done`.
- Load granted, `rb`=1 three cycles later -> `mem_abort` pulse, no `ld_done`, IDLE next cycle; then pending fetch granted.
- Aging on, `AGE_LIMIT`=4, continuous stores plus fetch -> fetch granted on 5th arbitration; aging off -> fetch never granted while stores persist.
- `rdy` low for 5 cycles with `mem_done` pulsed during it -> no done outputs, state unchanged; resume completes on next `mem_done`.
- Reset asserted while BUSY on store -> all outputs 0 immediately; after release, pending store re-granted with same fields.
